recon_tx_framer: RTL and testbench

//  Transmit-side counterpart of the reconfiguration frame receiver. Builds a reconfiguration

---
 rtl/recon_tx_framer.sv | 207 ++++++++++++++++++++
 tb/tb_recon_tx_framer.sv | 261 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/recon_tx_framer.sv
// Reconfiguration frame transmit framer: 46-byte ETH/IP/RMT header + 10-byte recon header + payload
// realigned by 56 bytes. Payload length checking is built when RECON_TX_LEN_CHECK_EN is defined.
module recon_tx_framer #(
  parameter int          DATA_WIDTH = 512,
  parameter int          KEEP_WIDTH = DATA_WIDTH / 8,
  parameter int          ADDR_WIDTH = 34,
  parameter logic [15:0] RECON_ID   = 16'hF0E1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [375:0]          hdr_template,
  input  logic [1:0]            s_axis_cmd_func,
  input  logic [7:0]            s_axis_cmd_id,
  input  logic [ADDR_WIDTH-1:0] s_axis_cmd_addr,
  input  logic [31:0]           s_axis_cmd_size,
  input  logic                  s_axis_cmd_payload,
  input  logic                  s_axis_cmd_valid,
  output logic                  s_axis_cmd_ready,
  input  logic [DATA_WIDTH-1:0] s_axis_tdata,
  input  logic [KEEP_WIDTH-1:0] s_axis_tkeep,
  input  logic                  s_axis_tvalid,
  input  logic                  s_axis_tlast,
  output logic                  s_axis_tready,
  output logic [DATA_WIDTH-1:0] m_axis_tdata,
  output logic [KEEP_WIDTH-1:0] m_axis_tkeep,
  output logic                  m_axis_tvalid,
  output logic                  m_axis_tlast,
  input  logic                  m_axis_tready,
  output logic                  status_frame_done,
  output logic                  status_len_err
);

  typedef enum logic [2:0] {IDLE, HDR_ONLY, HDR, BODY, FLUSH, DRAIN} state_t;

  state_t                  state;
  logic [1:0]              cmd_func_q;
  logic [7:0]              cmd_id_q;
  logic [ADDR_WIDTH-1:0]   cmd_addr_q;
  logic [31:0]             cmd_size_q;
  logic                    cmd_payload_q;
  logic [447:0]            hold_data;
  logic [55:0]             hold_keep;
  logic                    drain_q;
  logic [DATA_WIDTH-1:0]   m_tdata_q;
  logic [KEEP_WIDTH-1:0]   m_tkeep_q;
  logic                    m_tvalid_q;
  logic                    m_tlast_q;

  logic [79:0]             recon_hdr;
  logic [447:0]            hdr_beat;
  logic [447:0]            base_data;
  logic [55:0]             base_keep;
  logic                    adv;
  logic                    in_take;
  logic [KEEP_WIDTH-1:0]   eff_keep;
  logic                    eff_last;
  logic                    trunc;
  logic                    unused_tmpl;

`ifdef RECON_TX_LEN_CHECK_EN
  logic [31:0]             byte_cnt;
  logic [31:0]             cnt_next;
  logic [6:0]              beat_bytes;
  logic [32:0]             sum;
  logic [31:0]             rem;
  logic [63:0]             keep_mask;
  logic                    len_err;
  logic                    len_err_q;
`endif

  assign recon_hdr   = {3'b000, cmd_size_q, cmd_id_q, cmd_addr_q, ~cmd_payload_q, cmd_func_q};
  assign hdr_beat    = {recon_hdr, hdr_template[367:352], RECON_ID, hdr_template[335:0]};
  assign unused_tmpl = ^hdr_template[375:368];

  assign adv       = !m_tvalid_q || m_axis_tready;
  assign base_data = (state == HDR) ? hdr_beat : hold_data;
  assign base_keep = (state == HDR) ? '1 : hold_keep;

  assign s_axis_cmd_ready = !rst && (state == IDLE);
  assign s_axis_tready    = !rst && ((((state == HDR) || (state == BODY)) && adv) || (state == DRAIN));
  assign in_take          = s_axis_tvalid && s_axis_tready;

  assign m_axis_tdata      = m_tdata_q;
  assign m_axis_tkeep      = m_tkeep_q;
  assign m_axis_tvalid     = m_tvalid_q;
  assign m_axis_tlast      = m_tlast_q;
  assign status_frame_done = m_tvalid_q && m_axis_tready && m_tlast_q;

  always_comb begin
    eff_keep = s_axis_tkeep;
    eff_last = s_axis_tlast;
    trunc    = 1'b0;
`ifdef RECON_TX_LEN_CHECK_EN
    beat_bytes = '0;
    for (int unsigned i = 0; i < KEEP_WIDTH; i++) begin
      beat_bytes = beat_bytes + 7'(s_axis_tkeep[i]);
    end
    sum       = {1'b0, byte_cnt} + 33'(beat_bytes);
    cnt_next  = sum[32] ? '1 : sum[31:0];
    rem       = (byte_cnt < cmd_size_q) ? (cmd_size_q - byte_cnt) : '0;
    keep_mask = (rem >= 32'd64) ? '1 : ((64'd1 << rem[5:0]) - 64'd1);
    len_err   = 1'b0;
    // Size reached before tlast: cut this beat at the size boundary and drain the rest.
    if (!s_axis_tlast && (sum >= {1'b0, cmd_size_q})) begin
      trunc    = 1'b1;
      eff_last = 1'b1;
      len_err  = 1'b1;
      eff_keep = s_axis_tkeep & keep_mask;
    end else if (s_axis_tlast && (cnt_next != cmd_size_q)) begin
      len_err = 1'b1;
    end
`endif
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= IDLE;
      cmd_func_q    <= '0;
      cmd_id_q      <= '0;
      cmd_addr_q    <= '0;
      cmd_size_q    <= '0;
      cmd_payload_q <= 1'b0;
      hold_data     <= '0;
      hold_keep     <= '0;
      drain_q       <= 1'b0;
      m_tdata_q     <= '0;
      m_tkeep_q     <= '0;
      m_tvalid_q    <= 1'b0;
      m_tlast_q     <= 1'b0;
`ifdef RECON_TX_LEN_CHECK_EN
      byte_cnt      <= '0;
      len_err_q     <= 1'b0;
`endif
    end else begin
      if (m_axis_tready) m_tvalid_q <= 1'b0;
`ifdef RECON_TX_LEN_CHECK_EN
      len_err_q <= 1'b0;
`endif
      unique case (state)
        IDLE: begin
          if (s_axis_cmd_valid) begin
            cmd_func_q    <= s_axis_cmd_func;
            cmd_id_q      <= s_axis_cmd_id;
            cmd_addr_q    <= s_axis_cmd_addr;
            cmd_size_q    <= s_axis_cmd_size;
            cmd_payload_q <= s_axis_cmd_payload;
            drain_q       <= 1'b0;
`ifdef RECON_TX_LEN_CHECK_EN
            byte_cnt      <= '0;
`endif
            state         <= s_axis_cmd_payload ? HDR : HDR_ONLY;
          end
        end
        HDR_ONLY: begin
          if (adv) begin
            m_tdata_q  <= {64'b0, hdr_beat};
            m_tkeep_q  <= {8'h00, 56'hFF_FFFF_FFFF_FFFF};
            m_tlast_q  <= 1'b1;
            m_tvalid_q <= 1'b1;
            state      <= IDLE;
          end
        end
        HDR, BODY: begin
          if (in_take) begin
            m_tdata_q  <= {s_axis_tdata[63:0], base_data};
            m_tkeep_q  <= {eff_keep[7:0], base_keep};
            m_tvalid_q <= 1'b1;
            hold_data  <= s_axis_tdata[511:64];
            hold_keep  <= eff_keep[63:8];
            drain_q    <= trunc;
`ifdef RECON_TX_LEN_CHECK_EN
            byte_cnt   <= cnt_next;
            len_err_q  <= len_err;
`endif
            if (eff_last && (eff_keep[63:8] == '0)) begin
              m_tlast_q <= 1'b1;
              state     <= trunc ? DRAIN : IDLE;
            end else begin
              m_tlast_q <= 1'b0;
              state     <= eff_last ? FLUSH : BODY;
            end
          end
        end
        FLUSH: begin
          if (adv) begin
            m_tdata_q  <= {64'b0, hold_data};
            m_tkeep_q  <= {8'h00, hold_keep};
            m_tlast_q  <= 1'b1;
            m_tvalid_q <= 1'b1;
            state      <= drain_q ? DRAIN : IDLE;
          end
        end
        DRAIN: begin
          if (s_axis_tvalid && s_axis_tlast) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifdef RECON_TX_LEN_CHECK_EN
  assign status_len_err = len_err_q;
`else
  assign status_len_err = 1'b0;
`endif

endmodule

// File: tb/tb_recon_tx_framer.sv
// Self-checking bench for recon_tx_framer: byte-level reference model of the framed output stream.
module tb_recon_tx_framer;
  logic         clk = 1'b0;
  logic         rst;
  logic [375:0] hdr_template;
  logic [1:0]   s_axis_cmd_func;
  logic [7:0]   s_axis_cmd_id;
  logic [33:0]  s_axis_cmd_addr;
  logic [31:0]  s_axis_cmd_size;
  logic         s_axis_cmd_payload;
  logic         s_axis_cmd_valid;
  logic         s_axis_cmd_ready;
  logic [511:0] s_axis_tdata;
  logic [63:0]  s_axis_tkeep;
  logic         s_axis_tvalid;
  logic         s_axis_tlast;
  logic         s_axis_tready;
  logic [511:0] m_axis_tdata;
  logic [63:0]  m_axis_tkeep;
  logic         m_axis_tvalid;
  logic         m_axis_tlast;
  logic         m_axis_tready;
  logic         status_frame_done;
  logic         status_len_err;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  recon_tx_framer #(
    .DATA_WIDTH(512),
    .ADDR_WIDTH(34),
    .RECON_ID  (16'hF0E1)
  ) dut (
    .clk               (clk),
    .rst               (rst),
    .hdr_template      (hdr_template),
    .s_axis_cmd_func   (s_axis_cmd_func),
    .s_axis_cmd_id     (s_axis_cmd_id),
    .s_axis_cmd_addr   (s_axis_cmd_addr),
    .s_axis_cmd_size   (s_axis_cmd_size),
    .s_axis_cmd_payload(s_axis_cmd_payload),
    .s_axis_cmd_valid  (s_axis_cmd_valid),
    .s_axis_cmd_ready  (s_axis_cmd_ready),
    .s_axis_tdata      (s_axis_tdata),
    .s_axis_tkeep      (s_axis_tkeep),
    .s_axis_tvalid     (s_axis_tvalid),
    .s_axis_tlast      (s_axis_tlast),
    .s_axis_tready     (s_axis_tready),
    .m_axis_tdata      (m_axis_tdata),
    .m_axis_tkeep      (m_axis_tkeep),
    .m_axis_tvalid     (m_axis_tvalid),
    .m_axis_tlast      (m_axis_tlast),
    .m_axis_tready     (m_axis_tready),
    .status_frame_done (status_frame_done),
    .status_len_err    (status_len_err)
  );

  task automatic chk(input string tag, input logic [511:0] obs, input logic [511:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic new_template();
    for (int i = 0; i < 11; i++) hdr_template[32*i +: 32] = $urandom;
    hdr_template[375:352] = 24'($urandom);
  endtask

  // bp: 0 = always ready, 1 = toggle each cycle, 2 = random. abort_after > 0: reset after that many beats.
  task automatic run_frame(input logic [1:0] func, input logic [7:0] id, input logic [33:0] addr,
                           input logic [31:0] size, input logic pay, input int nbytes,
                           input int bp, input int abort_after);
    logic [447:0]  hdr;
    byte unsigned  exp_b[$];
    byte unsigned  pl[$];
    logic [511:0]  in_d[$];
    logic [63:0]   in_k[$];
    logic          in_l[$];
    logic [511:0]  d, ed, mask, held_d;
    logic [63:0]   k, ek, held_k;
    logic          held_l, sent, stalled;
    int            nout, ob, ib, cyc, dn, nerr, ne, exp_err, target;

    hdr = '0;
    hdr[367:0]   = hdr_template[367:0];
    hdr[351:336] = 16'hF0E1;
    hdr[369:368] = func;
    hdr[370]     = ~pay;
    hdr[404:371] = addr;
    hdr[412:405] = id;
    hdr[444:413] = size;
    for (int i = 0; i < 56; i++) exp_b.push_back(hdr[8*i +: 8]);

    exp_err = 0;
    if (pay) begin
      for (int i = 0; i < nbytes; i++) pl.push_back(8'($urandom));
      for (int b = 0; b * 64 < nbytes; b++) begin
        d = '0;
        k = '0;
        for (int j = 0; j < 64 && b * 64 + j < nbytes; j++) begin
          d[8*j +: 8] = pl[b*64 + j];
          k[j] = 1'b1;
        end
        in_d.push_back(d);
        in_k.push_back(k);
        in_l.push_back((b + 1) * 64 >= nbytes);
      end
      ne = nbytes;
`ifdef RECON_TX_LEN_CHECK_EN
      if (size != nbytes) exp_err = 1;
      if (size <= 64 * (in_d.size() - 1)) ne = int'(size);
`endif
      for (int i = 0; i < ne; i++) exp_b.push_back(pl[i]);
    end
    nout   = (exp_b.size() + 63) / 64;
    target = (abort_after > 0) ? abort_after : nout;

    sent = 1'b0; stalled = 1'b0; ob = 0; ib = 0; cyc = 0; dn = 0; nerr = 0;
    held_d = '0; held_k = '0; held_l = 1'b0;
    while (ob < target && cyc < 4000) begin
      @(negedge clk);
      s_axis_cmd_valid   = !sent;
      s_axis_cmd_func    = func;
      s_axis_cmd_id      = id;
      s_axis_cmd_addr    = addr;
      s_axis_cmd_size    = size;
      s_axis_cmd_payload = pay;
      s_axis_tvalid      = (ib < in_d.size());
      s_axis_tdata       = s_axis_tvalid ? in_d[ib] : '0;
      s_axis_tkeep       = s_axis_tvalid ? in_k[ib] : '0;
      s_axis_tlast       = s_axis_tvalid ? in_l[ib] : 1'b0;
      case (bp)
        0:       m_axis_tready = 1'b1;
        1:       m_axis_tready = cyc[0];
        default: m_axis_tready = 1'($urandom_range(0, 1));
      endcase
      #1;
      if (stalled) begin
        chk("stall_valid", m_axis_tvalid, 1'b1);
        chk("stall_data", m_axis_tdata, held_d);
        chk("stall_keep", m_axis_tkeep, held_k);
        chk("stall_last", m_axis_tlast, held_l);
      end
      if (m_axis_tvalid && m_axis_tready) begin
        ed = '0;
        ek = '0;
        for (int j = 0; j < 64 && ob * 64 + j < exp_b.size(); j++) begin
          ed[8*j +: 8] = exp_b[ob*64 + j];
          ek[j] = 1'b1;
        end
        for (int j = 0; j < 64; j++) mask[8*j +: 8] = {8{ek[j]}};
        chk($sformatf("beat%0d_keep", ob), m_axis_tkeep, ek);
        chk($sformatf("beat%0d_data", ob), m_axis_tdata & mask, ed);
        chk($sformatf("beat%0d_last", ob), m_axis_tlast, ob == nout - 1);
        ob++;
      end
      if (status_frame_done) dn++;
      if (status_len_err) nerr++;
      if (s_axis_cmd_valid && s_axis_cmd_ready) sent = 1'b1;
      if (s_axis_tvalid && s_axis_tready) ib++;
      stalled = m_axis_tvalid && !m_axis_tready;
      held_d  = m_axis_tdata;
      held_k  = m_axis_tkeep;
      held_l  = m_axis_tlast;
      cyc++;
    end
    chk("beats_out", ob, target);

    if (abort_after > 0) begin
      @(negedge clk);
      rst              = 1'b1;
      s_axis_cmd_valid = 1'b0;
      s_axis_tvalid    = 1'b0;
      m_axis_tready    = 1'b1;
      @(posedge clk);
      #1;
      chk("rst_mid_tvalid", m_axis_tvalid, 1'b0);
      chk("rst_mid_tlast", m_axis_tlast, 1'b0);
      chk("rst_mid_s_tready", s_axis_tready, 1'b0);
      chk("rst_mid_cmd_ready", s_axis_cmd_ready, 1'b0);
      chk("rst_mid_done", status_frame_done, 1'b0);
      @(negedge clk);
      rst = 1'b0;
      return;
    end

    for (int t = 0; t < 40; t++) begin
      @(negedge clk);
      s_axis_cmd_valid = 1'b0;
      s_axis_tvalid    = (ib < in_d.size());
      s_axis_tdata     = s_axis_tvalid ? in_d[ib] : '0;
      s_axis_tkeep     = s_axis_tvalid ? in_k[ib] : '0;
      s_axis_tlast     = s_axis_tvalid ? in_l[ib] : 1'b0;
      m_axis_tready    = 1'b1;
      #1;
      if (status_frame_done) dn++;
      if (status_len_err) nerr++;
      if (s_axis_tvalid && s_axis_tready) ib++;
      if (ib >= in_d.size() && t >= 2) break;
    end
    s_axis_tvalid = 1'b0;
    chk("frame_done_cnt", dn, 1);
    chk("input_consumed", ib, in_d.size());
    chk("idle_tvalid", m_axis_tvalid, 1'b0);
    chk("idle_cmd_ready", s_axis_cmd_ready, 1'b1);
    chk("len_err_cnt", nerr, exp_err);
  endtask

  initial begin
    rst                = 1'b1;
    s_axis_cmd_func    = '0;
    s_axis_cmd_id      = '0;
    s_axis_cmd_addr    = '0;
    s_axis_cmd_size    = '0;
    s_axis_cmd_payload = 1'b0;
    s_axis_cmd_valid   = 1'b0;
    s_axis_tdata       = '0;
    s_axis_tkeep       = '0;
    s_axis_tvalid      = 1'b0;
    s_axis_tlast       = 1'b0;
    m_axis_tready      = 1'b1;
    hdr_template       = '0;
    new_template();
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("reset_tvalid", m_axis_tvalid, 1'b0);
    chk("reset_tlast", m_axis_tlast, 1'b0);
    chk("reset_cmd_ready", s_axis_cmd_ready, 1'b0);
    chk("reset_s_tready", s_axis_tready, 1'b0);
    chk("reset_done", status_frame_done, 1'b0);
    chk("reset_len_err", status_len_err, 1'b0);
    rst = 1'b0;

    run_frame(2'b01, 8'h5A, 34'h1_0000_0000, 32'd4096, 1'b0, 0, 0, 0);
    run_frame(2'b10, 8'h11, 34'h0_1234_5678, 32'd64, 1'b1, 64, 0, 0);
    run_frame(2'b11, 8'h22, 34'h2_0000_0040, 32'd100, 1'b1, 100, 0, 0);
    run_frame(2'b00, 8'h33, 34'h3_ABCD_0000, 32'd512, 1'b1, 512, 1, 0);
    run_frame(2'b01, 8'h44, 34'h0_0000_1000, 32'd512, 1'b1, 512, 0, 2);
    run_frame(2'b10, 8'h55, 34'h1_8000_0000, 32'd200, 1'b1, 200, 0, 0);
    run_frame(2'b01, 8'h66, 34'h0_0000_0008, 32'd8, 1'b1, 8, 2, 0);
    run_frame(2'b11, 8'h77, 34'h0_0000_0009, 32'd9, 1'b1, 9, 0, 0);
    run_frame(2'b00, 8'h88, 34'h3_FFFF_FFFF, 32'd1, 1'b1, 1, 1, 0);
`ifdef RECON_TX_LEN_CHECK_EN
    run_frame(2'b01, 8'h99, 34'h0_0000_0100, 32'd64, 1'b1, 128, 0, 0);
`endif
    for (int n = 0; n < 12; n++) begin
      int nb;
      new_template();
      nb = $urandom_range(1, 400);
      run_frame(2'($urandom), 8'($urandom), {2'($urandom), 32'($urandom)}, 32'(nb),
                1'($urandom_range(0, 3) != 0), nb, $urandom_range(0, 2), 0);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
